// File: rtl/runner_game_sequencer.sv
// Game sequencer for the runner game: owns the IDLE/RUN/OVER FSM and schedules
// the obstacle position, speed ramp, score and jump phase on each frame tick.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   S_IDLE | after reset; waits for a start press, jump presses are dropped
//   S_RUN  | obstacle moves, score counts, jumps play out; collision ends it
//   S_OVER | all outputs frozen, game_over=1; a start press restarts the game
module runner_game_sequencer #(
    parameter int OBS_START_X    = 800,
    parameter int SPEED_INIT     = 1,
    parameter int SPEED_MAX      = 15,
    parameter int JUMP_STEPS     = 21,
    parameter int TICKS_PER_STEP = 6,
    parameter int SCORE_W        = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               jump_btn,
    input  logic               collision,
    output logic [1:0]         state,
    output logic               jump_active,
    output logic [4:0]         jump_idx,
    output logic [9:0]         obs_x,
    output logic [4:0]         speed,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP + 1);

    localparam logic [9:0]       OBS_RELOAD = 10'(OBS_START_X);
    localparam logic [4:0]       SPEED_RST  = 5'(SPEED_INIT);
    localparam logic [4:0]       SPEED_TOP  = 5'(SPEED_MAX);
    localparam logic [4:0]       IDX_LAST   = 5'(JUMP_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } game_state_t;

    game_state_t        state_q, state_d;
    logic               jump_active_q, jump_active_d;
    logic [4:0]         jump_idx_q, jump_idx_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [9:0]         obs_x_q, obs_x_d;
    logic [4:0]         speed_q, speed_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic start_q, jump_q;
    logic start_pend_q, jump_pend_q;
    logic start_req, jump_req;

    // A press landing on the tick cycle itself is folded in so it is not lost.
    assign start_req = start_pend_q | (start_btn & ~start_q);
    assign jump_req  = jump_pend_q  | (jump_btn  & ~jump_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            jump_q       <= 1'b0;
            start_pend_q <= 1'b0;
            jump_pend_q  <= 1'b0;
        end else begin
            start_q      <= start_btn;
            jump_q       <= jump_btn;
            start_pend_q <= frame_tick ? 1'b0 : start_req;
            jump_pend_q  <= frame_tick ? 1'b0 : jump_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            jump_active_q <= 1'b0;
            jump_idx_q    <= 5'd0;
            tick_cnt_q    <= '0;
            obs_x_q       <= OBS_RELOAD;
            speed_q       <= SPEED_RST;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            jump_active_q <= jump_active_d;
            jump_idx_q    <= jump_idx_d;
            tick_cnt_q    <= tick_cnt_d;
            obs_x_q       <= obs_x_d;
            speed_q       <= speed_d;
            score_q       <= score_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        jump_active_d = jump_active_q;
        jump_idx_d    = jump_idx_q;
        tick_cnt_d    = tick_cnt_q;
        obs_x_d       = obs_x_q;
        speed_d       = speed_q;
        score_d       = score_q;

        if (frame_tick) begin
            unique case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_req) begin
                        state_d       = S_RUN;
                        obs_x_d       = OBS_RELOAD;
                        speed_d       = SPEED_RST;
                        score_d       = '0;
                        jump_active_d = 1'b0;
                        jump_idx_d    = 5'd0;
                        tick_cnt_d    = '0;
                    end
                end
                S_RUN: begin
                    if (collision) begin
                        state_d = S_OVER;
                    end else begin
                        // Compare before subtracting so obs_x can never wrap below zero.
                        if (obs_x_q <= {5'd0, speed_q}) begin
                            obs_x_d = OBS_RELOAD;
                            if (speed_q < SPEED_TOP) speed_d = speed_q + 5'd1;
                            if (score_q != '1) score_d = score_q + SCORE_W'(1);
                        end else begin
                            obs_x_d = obs_x_q - {5'd0, speed_q};
                        end

                        if (!jump_active_q) begin
                            if (jump_req) begin
                                jump_active_d = 1'b1;
                                jump_idx_d    = 5'd0;
                                tick_cnt_d    = '0;
                            end
                        end else if (tick_cnt_q == CNT_LAST) begin
                            tick_cnt_d = '0;
                            if (jump_idx_q == IDX_LAST) begin
                                jump_active_d = 1'b0;
                                jump_idx_d    = 5'd0;
                            end else begin
                                jump_idx_d = jump_idx_q + 5'd1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign jump_active = jump_active_q;
    assign jump_idx    = jump_idx_q;
    assign obs_x       = obs_x_q;
    assign speed       = speed_q;
    assign score       = score_q;
    assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_runner_game_sequencer.sv
// Scoreboard bench for runner_game_sequencer: a behavioural game model predicts
// every post-tick output vector, which is queued and compared after the tick edge.
module tb_runner_game_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic        jump_btn = 1'b0;
    logic        collision = 1'b0;
    logic [1:0]  state;
    logic        jump_active;
    logic [4:0]  jump_idx;
    logic [9:0]  obs_x;
    logic [4:0]  speed;
    logic [13:0] score;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    runner_game_sequencer dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
        .jump_btn(jump_btn), .collision(collision), .state(state),
        .jump_active(jump_active), .jump_idx(jump_idx), .obs_x(obs_x),
        .speed(speed), .score(score), .game_over(game_over)
    );

    // {state, jump_active, jump_idx, obs_x, speed, score, game_over}
    logic [37:0] obs_v;
    assign obs_v = {state, jump_active, jump_idx, obs_x, speed, score, game_over};

    localparam logic [37:0] RESET_VEC = {2'd0, 1'b0, 5'd0, 10'd800, 5'd1, 14'd0, 1'b0};

    // behavioural model: jump tracked by its age in ticks, index derived from it
    int          m_state;
    bit          m_ja;
    int          m_age;
    int          m_obs;
    int          m_speed;
    int          m_score;
    bit          m_sp, m_jp;
    logic [37:0] sb[$];
    logic [37:0] last_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [37:0] model_vec();
        logic [4:0] idx;
        idx = m_ja ? 5'(m_age / 6) : 5'd0;
        return {2'(m_state), m_ja, idx, 10'(m_obs), 5'(m_speed), 14'(m_score), (m_state == 2)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ja = 0; m_age = 0; m_obs = 800; m_speed = 1; m_score = 0;
        m_sp = 0; m_jp = 0;
    endtask

    task automatic model_tick(input bit coll);
        if (m_state != 1) begin
            if (m_sp) begin
                m_state = 1; m_obs = 800; m_speed = 1; m_score = 0; m_ja = 0; m_age = 0;
            end
        end else if (coll) begin
            m_state = 2;
        end else begin
            if (m_obs <= m_speed) begin
                m_obs = 800;
                m_speed = (m_speed + 1 > 15) ? 15 : m_speed + 1;
                m_score = (m_score == 16383) ? 16383 : m_score + 1;
            end else begin
                m_obs = m_obs - m_speed;
            end
            if (!m_ja) begin
                if (m_jp) begin m_ja = 1; m_age = 0; end
            end else begin
                m_age++;
                if (m_age == 126) begin m_ja = 0; m_age = 0; end
            end
        end
        m_sp = 0;
        m_jp = 0;
    endtask

    task automatic do_tick(input bit coll);
        logic [37:0] exp;
        @(posedge clk);
        @(negedge clk);
        check("hold", 64'(obs_v), 64'(last_exp));
        frame_tick = 1'b1;
        collision  = coll;
        model_tick(coll);
        sb.push_back(model_vec());
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        collision  = 1'b0;
        exp = sb.pop_front();
        check("tick", 64'(obs_v), 64'(exp));
        last_exp = exp;
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        @(negedge clk) start_btn = 1'b0;
        m_sp = 1;
    endtask

    task automatic press_jump();
        @(negedge clk) jump_btn = 1'b1;
        @(negedge clk) jump_btn = 1'b0;
        m_jp = 1;
    endtask

    initial begin
        int s0, pre_obs, pre_score;
        model_reset();
        last_exp = RESET_VEC;
        repeat (3) @(posedge clk);
        #1 check("reset_vec", 64'(obs_v), 64'(RESET_VEC));
        @(negedge clk) rst = 1'b0;

        // idle: ticks with no start, a jump press is dropped
        press_jump();
        for (int i = 0; i < 3; i++) do_tick(1'b0);
        check("idle_state", 64'(state), 64'd0);
        check("idle_obs", 64'(obs_x), 64'd800);

        // first obstacle wrap
        press_start();
        do_tick(1'b0);
        check("run_state", 64'(state), 64'd1);
        check("run_no_jump", 64'(jump_active), 64'd0);
        for (int i = 0; i < 799; i++) do_tick(1'b0);
        check("obs_before_wrap", 64'(obs_x), 64'd1);
        do_tick(1'b0);
        check("wrap_obs", 64'(obs_x), 64'd800);
        check("wrap_speed", 64'(speed), 64'd2);
        check("wrap_score", 64'(score), 64'd1);

        // jump sequence, second press mid-jump dropped, start in RUN ignored
        press_jump();
        do_tick(1'b0);
        check("jump_start", 64'(jump_active), 64'd1);
        check("jump_idx0", 64'(jump_idx), 64'd0);
        for (int i = 0; i < 6; i++) do_tick(1'b0);
        check("jump_idx1", 64'(jump_idx), 64'd1);
        for (int i = 0; i < 54; i++) do_tick(1'b0);
        press_jump();
        press_start();
        for (int i = 0; i < 65; i++) do_tick(1'b0);
        check("jump_last_act", 64'(jump_active), 64'd1);
        check("jump_last_idx", 64'(jump_idx), 64'd20);
        do_tick(1'b0);
        check("jump_end_act", 64'(jump_active), 64'd0);
        check("jump_end_idx", 64'(jump_idx), 64'd0);
        for (int i = 0; i < 8; i++) do_tick(1'b0);
        check("no_requeue", 64'(jump_active), 64'd0);

        // ramp speed to saturation, then three more wraps
        for (int i = 0; i < 20000 && m_speed < 15; i++) do_tick(1'b0);
        check("speed_sat", 64'(speed), 64'd15);
        s0 = m_score;
        for (int i = 0; i < 2000 && m_score < s0 + 3; i++) do_tick(1'b0);
        check("sat_score", 64'(score), 64'(s0 + 3));
        check("sat_speed", 64'(speed), 64'd15);

        // collision on a wrap tick freezes everything
        for (int i = 0; i < 100 && !(m_obs <= m_speed); i++) do_tick(1'b0);
        pre_obs   = m_obs;
        pre_score = m_score;
        do_tick(1'b1);
        check("over_state", 64'(state), 64'd2);
        check("over_flag", 64'(game_over), 64'd1);
        check("over_obs", 64'(obs_x), 64'(pre_obs));
        check("over_score", 64'(score), 64'(pre_score));
        press_jump();
        do_tick(1'b0);
        do_tick(1'b1);
        do_tick(1'b0);
        check("over_frozen_obs", 64'(obs_x), 64'(pre_obs));
        press_start();
        do_tick(1'b0);
        check("restart_state", 64'(state), 64'd1);
        check("restart_obs", 64'(obs_x), 64'd800);
        check("restart_speed", 64'(speed), 64'd1);
        check("restart_score", 64'(score), 64'd0);

        // asynchronous reset mid-jump
        press_jump();
        for (int i = 0; i < 30; i++) do_tick(1'b0);
        check("pre_rst_jump", 64'(jump_active), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("async_rst", 64'(obs_v), 64'(RESET_VEC));
        model_reset();
        last_exp = RESET_VEC;
        @(negedge clk) rst = 1'b0;

        // reset also discards a pending start
        press_start();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        m_sp = 0;
        do_tick(1'b0);
        check("rst_clears_pend", 64'(state), 64'd0);
        press_start();
        do_tick(1'b0);
        check("post_rst_run", 64'(state), 64'd1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
